// File: rtl/cpu_pkg.sv
// Shared types and constants for the Thumb core front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int THUMB_INSTR_W  = 16;
  localparam int PC_STEP        = 2;
  localparam int BRANCH_PC_BIAS = 4;

endpackage

// File: rtl/branch_target_calc.sv
// Taken-branch target: br_pc + 4 + (sext(br_off) << 1), wrapping, halfword aligned.
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 11
) (
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_off,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] sum;

  always_comb begin
    off_ext = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    sum     = br_pc + ADDR_W'(BRANCH_PC_BIAS) + (off_ext << 1);
    target  = {sum[ADDR_W-1:1], 1'b0};
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch stage: PC register, single-outstanding halfword fetch, one-entry
// instruction buffer toward decode, and branch redirect with stale-response drain.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                OFF_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [THUMB_INSTR_W-1:0] imem_rdata,
  output logic                     instr_valid,
  output logic [THUMB_INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     br_valid,
  input  logic                     do_branch,
  input  logic [ADDR_W-1:0]        br_pc,
  input  logic [OFF_W-1:0]         br_off
);

  // Handshakes: a fetch is accepted on an edge where imem_req && imem_gnt;
  // decode takes instr on an edge where instr_valid && instr_ready.
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              fire;

  branch_target_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_target (
    .br_pc  (br_pc),
    .br_off (br_off),
    .target (target)
  );

  // Only request when the buffer is free (or being drained this cycle),
  // so a returning response always has somewhere to land.
  assign imem_req  = (state == FETCH) && (!instr_valid || instr_ready);
  assign imem_addr = {pc[ADDR_W-1:1], 1'b0};
  assign fire      = imem_req && imem_gnt;
  assign redirect  = br_valid && do_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      if (instr_valid && instr_ready) instr_valid <= 1'b0;

      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          if (redirect) begin
            pc <= target;
            // A grant in the same cycle leaves a stale response in flight.
            if (fire) state <= DRAIN;
          end else if (fire) begin
            req_addr <= pc;
            pc       <= pc + ADDR_W'(PC_STEP);
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (redirect) begin
            pc    <= target;
            state <= imem_rvalid ? FETCH : DRAIN;
          end else if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= req_addr;
            instr_valid <= 1'b1;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) pc <= target;
          if (imem_rvalid) state <= FETCH;
        end

        default: state <= IDLE;
      endcase

      // Flush wins over both consume and reload.
      if (redirect) instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: memory responder, expected-instruction
// scoreboard popped by a monitor on every decode handshake.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_valid;
  logic        do_branch;
  logic [31:0] br_pc;
  logic [10:0] br_off;

  int n_checks = 0;
  int n_err    = 0;

  logic [47:0] exp_q[$];

  // responder controls and state
  bit          gnt_en    = 1'b1;
  int          rsp_delay = 1;
  bit          dead_next = 1'b0;
  bit          pending   = 1'b0;
  logic [31:0] p_addr    = '0;
  int          cnt       = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .OFF_W    (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .br_valid    (br_valid),
    .do_branch   (do_branch),
    .br_pc       (br_pc),
    .br_off      (br_off)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [15:0] data);
    exp_q.push_back({pc, data});
  endtask

  // Waits (bounded) for a buffered instruction, then holds ready for one cycle.
  task automatic consume_one(input string tag);
    int t = 0;
    while (instr_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: instr_valid=%b after %0d cycles, expected 1", tag, instr_valid, t);
    end else begin
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
    end
  endtask

  // Memory: drives just after negedge, samples the coming edge just before it.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_gnt = gnt_en;
      if (pending && cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = dead_next ? 16'hDEAD : {4'hA, p_addr[11:0]};
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      #3;
      if (imem_rvalid) begin
        pending   = 1'b0;
        dead_next = 1'b0;
      end else if (pending && cnt > 0) begin
        cnt--;
      end
      if (imem_req && imem_gnt) begin
        pending = 1'b1;
        p_addr  = imem_addr;
        cnt     = rsp_delay - 1;
      end
    end
  end

  // Monitor: every decode handshake pops one expected {pc, instr}.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL instr_unexpected: got pc=%h instr=%h, expected none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if ({instr_pc, instr} !== e) begin
            n_err++;
            $display("FAIL instr_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                     instr_pc, instr, e[47:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    n_err++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    br_valid    = 1'b0;
    do_branch   = 1'b0;
    br_pc       = '0;
    br_off      = '0;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   32'(imem_req),    32'h0);
    check("rst_addr",  imem_addr,        32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", 32'(instr),       32'h0);
    check("rst_pc",    instr_pc,         32'h0);

    // release; IDLE for one edge, request presented for the 2nd edge
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("idle_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("first_req",  32'(imem_req), 32'h1);
    check("first_addr", imem_addr,      32'h0);

    // sequential fetch
    push_exp(32'h0, 16'hA000);
    push_exp(32'h2, 16'hA002);
    push_exp(32'h4, 16'hA004);
    push_exp(32'h6, 16'hA006);
    consume_one("seq0");
    consume_one("seq2");
    consume_one("seq4");

    // backpressure: instruction held, no new request
    begin
      int t = 0;
      while (instr_valid !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_req",   32'(imem_req), 32'h0);
      check("stall_pc",    instr_pc,      32'h6);
      check("stall_instr", 32'(instr),    32'hA006);
      @(negedge clk);
    end
    rsp_delay = 3;
    consume_one("seq6");

    // taken branch while WAIT: drain stale 0xDEAD, refetch at 0x100
    br_valid  = 1'b1;
    do_branch = 1'b1;
    br_pc     = 32'h0000_0100;
    br_off    = 11'h7FE;
    dead_next = 1'b1;
    rsp_delay = 1;
    @(negedge clk);
    br_valid  = 1'b0;
    do_branch = 1'b0;
    check("drain_req",    32'(imem_req),    32'h0);
    check("drain_valid",  32'(instr_valid), 32'h0);
    @(negedge clk);
    check("drain_req2",   32'(imem_req),    32'h0);
    check("drain_valid2", 32'(instr_valid), 32'h0);
    @(negedge clk);
    check("redir_req",   32'(imem_req),    32'h1);
    check("redir_addr",  imem_addr,        32'h0000_0100);
    check("redir_valid", 32'(instr_valid), 32'h0);
    push_exp(32'h0000_0100, 16'hA100);
    @(negedge clk);
    gnt_en = 1'b0;
    consume_one("redir100");

    // taken branch in FETCH without grant, target wraps to 0x2
    check("hold_req",  32'(imem_req), 32'h1);
    check("hold_addr", imem_addr,     32'h0000_0102);
    br_valid  = 1'b1;
    do_branch = 1'b1;
    br_pc     = 32'hFFFF_FFFC;
    br_off    = 11'h001;
    @(negedge clk);
    br_valid  = 1'b0;
    do_branch = 1'b0;
    check("wrap_req",   32'(imem_req),    32'h1);
    check("wrap_addr",  imem_addr,        32'h0000_0002);
    check("wrap_valid", 32'(instr_valid), 32'h0);
    push_exp(32'h2, 16'hA002);
    gnt_en = 1'b1;
    consume_one("wrap2");

    // not-taken branch, then unqualified do_branch: both ignored
    br_valid  = 1'b1;
    do_branch = 1'b0;
    br_pc     = 32'h0000_0100;
    br_off    = 11'h7FE;
    push_exp(32'h4, 16'hA004);
    push_exp(32'h6, 16'hA006);
    @(negedge clk);
    br_valid  = 1'b0;
    do_branch = 1'b1;
    check("nt_valid", 32'(instr_valid), 32'h1);
    check("nt_pc",    instr_pc,         32'h4);
    consume_one("nt4");
    rsp_delay = 2;
    consume_one("nt6");
    do_branch = 1'b0;

    // asynchronous reset while WAIT; the late response lands in IDLE
    dead_next = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   32'(imem_req),    32'h0);
    check("arst_addr",  imem_addr,        32'h0);
    check("arst_valid", 32'(instr_valid), 32'h0);
    check("arst_instr", 32'(instr),       32'h0);
    check("arst_pc",    instr_pc,         32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_delay = 1;
    #2;
    check("arst_idle_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("restart_req",   32'(imem_req),    32'h1);
    check("restart_addr",  imem_addr,        32'h0);
    check("restart_valid", 32'(instr_valid), 32'h0);
    push_exp(32'h0, 16'hA000);
    consume_one("restart0");

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
